matmul_sequencer: RTL and testbench
===================================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: APB data width.
REQ-002 Parameter ADDR_WIDTH, default 16: APB address width.
REQ-003 Parameter DEPTH, default 64: instruction memory entries, power of two, >=2.
REQ-004 Parameter TIMEOUT, default 4096: max cycles per wait; must be >=1.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 ld_we_i  in  1  instruction-memory write strobe; accepted only in IDLE.
REQ-008 ld_addr_i  in  $clog2(DEPTH)  instruction-memory write address.
REQ-009 ld_data_i  in  2+ADDR_WIDTH+DATA_WIDTH  instruction {op[1:0],addr,data}.
REQ-010 start_i  in  1  pulse; begins execution at entry 0.
REQ-011 psel_o, penable_o, pwrite_o  out  1 each  APB master controls.
REQ-012 paddr_o  out  ADDR_WIDTH; pwdata_o  out  DATA_WIDTH.
REQ-013 prdata_i  in  DATA_WIDTH; pready_i  in  1  APB slave response.
REQ-014 dut_done_i  in  1  matmul completion level from the DUT.
REQ-015 busy_o  out  1  high from the start_i acceptance until DONE is entered.
REQ-016 done_o  out  1  one-cycle pulse when the run finishes.
REQ-017 err_cnt_o  out  16  saturating mismatch count; timeout_o  out  1  sticky timeout flag.
REQ-018 rd_data_o  out  DATA_WIDTH  last captured read data; rd_valid_o  out  1  one-cycle pulse.

Function
REQ-019 Ops: 00 WRITE addr<=data; 01 READ addr and check against data; 10 WAIT until dut_done_i=1; 11 END.
REQ-020 States: IDLE, FETCH, SETUP, ACCESS, WAIT, FINISH; FINISH returns to IDLE next cycle.
REQ-021 IDLE->FETCH on start_i; pc<=0, err_cnt_o<=0, timeout_o<=0; start_i ignored when not IDLE.
REQ-022 FETCH: registered memory read, 1 cycle; WRITE/READ->SETUP, WAIT->WAIT, END->FINISH.
REQ-023 SETUP: psel_o=1, penable_o=0, paddr/pwrite/pwdata driven; next cycle ACCESS.
REQ-024 ACCESS: psel_o=1, penable_o=1; hold all APB outputs until pready_i=1; then pc++ and go to FETCH.
REQ-025 APB outputs stay stable from SETUP through ACCESS completion; psel_o=0 in all other states.
REQ-026 READ completion: rd_data_o<=prdata_i, rd_valid_o pulses in the cycle after pready_i.
REQ-027 WAIT: per-op cycle counter from 0; dut_done_i=1 -> pc++ and go to FETCH.
REQ-028 WAIT timeout: counter reaching TIMEOUT with no done sets timeout_o; the run aborts to FINISH.
REQ-029 ACCESS timeout: pready_i low for TIMEOUT cycles sets timeout_o; the run aborts to FINISH with psel_o deasserted.
REQ-030 pc wrap: executing entry DEPTH-1 without END goes to FINISH; pc never wraps to 0.
REQ-031 done_o pulses in FINISH; busy_o=0 in FINISH and IDLE.
REQ-032 err_cnt_o saturates at 16'hFFFF.
REQ-033 ld_we_i outside IDLE is dropped; memory is not cleared by reset.

Reset
REQ-034 In the cycle after rst_i=1: state=IDLE, pc=0, all outputs 0 (psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, busy_o, done_o, err_cnt_o, timeout_o, rd_data_o, rd_valid_o).
REQ-035 rst_i mid-transfer aborts immediately and sends no further APB phase; instruction memory contents are retained.

Configuration
REQ-036 Macro MATMUL_SEQ_COMPARE_EN defined: READ compares prdata_i to the data field, and each mismatch increments err_cnt_o.
REQ-037 Macro undefined: no comparator is built, err_cnt_o is tied to 0, and READ only captures rd_data_o.

Verification
REQ-038 Load {WRITE 0x0004,0xA5A5_0001; END}, start, pready_i=1 -> one SETUP+ACCESS with paddr 0x0004; done_o 4-5 cycles after start; err_cnt_o=0.
REQ-039 READ 0x0010 expect 0x1234, slave returns 0x1235 with 3 wait states -> penable held 4 cycles, rd_data_o=0x1235, err_cnt_o=1 (0 without the macro).
REQ-040 WAIT, TIMEOUT=16, dut_done_i held low -> timeout_o=1 after 16 WAIT cycles, done_o pulses, busy_o falls.
REQ-041 rst_i asserted during ACCESS -> next cycle psel_o=0, state IDLE; a new start replays the retained program correctly.
REQ-042 Program of DEPTH WRITEs with no END -> DEPTH transfers, then done_o; start_i pulsed while busy is ignored.

Source files
------------

// File: rtl/matmul_sequencer.sv
// APB master that replays a loaded program of WRITE / READ / WAIT / END instructions.
// Define MATMUL_SEQ_COMPARE_EN to build the read-data comparator that drives err_cnt_o.
module matmul_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int TIMEOUT    = 4096,
  localparam int PC_W      = $clog2(DEPTH),
  localparam int IW        = 2 + ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ld_we_i,
  input  logic [PC_W-1:0]       ld_addr_i,
  input  logic [IW-1:0]         ld_data_i,
  input  logic                  start_i,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  dut_done_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           err_cnt_o,
  output logic                  timeout_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_WAIT   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WAIT  = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(DEPTH - 1);

  logic [IW-1:0] mem [DEPTH];

  state_t                  state_q, state_d;
  logic [PC_W-1:0]         pc_q, pc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]           instr_q;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  logic                    timeout_q, timeout_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;

  logic [1:0]              op_s;
  logic [ADDR_WIDTH-1:0]   addr_s;
  logic [DATA_WIDTH-1:0]   data_s;
  logic                    last_s;

  assign op_s   = instr_q[IW-1 -: 2];
  assign addr_s = instr_q[DATA_WIDTH +: ADDR_WIDTH];
  assign data_s = instr_q[DATA_WIDTH-1:0];
  assign last_s = (pc_q == PC_LAST);

  // Program memory: loads only while idle, contents survive reset.
  always_ff @(posedge clk_i) begin
    if (ld_we_i && (state_q == S_IDLE)) begin
      mem[ld_addr_i] <= ld_data_i;
    end
  end

  // Next-state, program counter, APB and status computation.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    err_cnt_d  = err_cnt_q;
    timeout_d  = timeout_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          err_cnt_d = 16'h0000;
          timeout_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        cnt_d = '0;
        case (op_s)
          OP_WRITE, OP_READ: begin
            state_d  = S_SETUP;
            pwrite_d = (op_s == OP_WRITE);
            paddr_d  = addr_s;
            pwdata_d = data_s;
          end
          OP_WAIT: state_d = S_WAIT;
          OP_END:  state_d = S_FINISH;
          default: state_d = S_FINISH;
        endcase
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (pready_i) begin
          if (!pwrite_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = prdata_i;
`ifdef MATMUL_SEQ_COMPARE_EN
            // pwdata_q still holds the expected value of a READ.
            if ((prdata_i != pwdata_q) && (err_cnt_q != 16'hFFFF)) begin
              err_cnt_d = err_cnt_q + 16'h0001;
            end else begin
              err_cnt_d = err_cnt_q;
            end
`else
            err_cnt_d = 16'h0000;
`endif
          end else begin
            rd_valid_d = 1'b0;
          end
          if (last_s) begin
            state_d = S_FINISH;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
          end
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (dut_done_i) begin
          if (last_s) begin
            state_d = S_FINISH;
          end else begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
          end
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d = (state_d == S_ACCESS);
    busy_d    = (state_d != S_IDLE) && (state_d != S_FINISH);
    done_d    = (state_d == S_FINISH);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      cnt_q      <= '0;
      instr_q    <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_cnt_q  <= 16'h0000;
      timeout_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      instr_q    <= mem[pc_d];
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_cnt_q  <= err_cnt_d;
      timeout_q  <= timeout_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign psel_o     = psel_q;
  assign penable_o  = penable_q;
  assign pwrite_o   = pwrite_q;
  assign paddr_o    = paddr_q;
  assign pwdata_o   = pwdata_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_cnt_o  = err_cnt_q;
  assign timeout_o  = timeout_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: a program-level reference model predicts APB
// transfers, read data and run results; a monitor compares them as the DUT presents them.
module tb_matmul_sequencer;
  localparam int DW = 32, AW = 16, DEPTH = 16, TMO = 16, PCW = 4, IW = 2 + AW + DW;

  logic clk = 1'b0;
  logic rst_i = 1'b0, ld_we_i = 1'b0, start_i = 1'b0;
  logic [PCW-1:0] ld_addr_i = '0;
  logic [IW-1:0] ld_data_i = '0;
  logic psel_o, penable_o, pwrite_o, busy_o, done_o, timeout_o, rd_valid_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o, rd_data_o;
  logic [DW-1:0] prdata_i = '0;
  logic pready_i = 1'b0, dut_done_i = 1'b0;
  logic [15:0] err_cnt_o;

  always #5 clk = ~clk;

  matmul_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i),
    .start_i(start_i), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i),
    .dut_done_i(dut_done_i), .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o),
    .timeout_o(timeout_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o));

  typedef struct { logic w; logic [AW-1:0] a; logic [DW-1:0] d; } xfer_t;

  xfer_t         exp_x[$];
  logic [DW-1:0] exp_rd[$];
  logic [16:0]   exp_done[$];
  int            ws_q[$];
  logic [DW-1:0] rsp_q[$];

  logic [IW-1:0] prog [DEPTH];
  logic [DW-1:0] rsp_arr [DEPTH];
  int            ws_arr [DEPTH];

  int vec = 0, miss = 0;
  int done_mode = 0;
  bit in_xfer = 1'b0;
  int ws_left = 0;
  logic [DW-1:0] cur_rsp = '0;
  logic [AW-1:0] setup_a = '0;
  logic          setup_w = 1'b0;
  logic [DW-1:0] setup_d = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    exp_x.delete(); exp_rd.delete(); exp_done.delete(); ws_q.delete(); rsp_q.delete();
    in_xfer = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; start_i = 1'b0; ld_we_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    flush();
  endtask

  task automatic fill_end();
    for (int i = 0; i < DEPTH; i++) begin
      prog[i] = {2'b11, {(IW-2){1'b0}}};
      rsp_arr[i] = '0;
      ws_arr[i] = 0;
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      ld_we_i = 1'b1; ld_addr_i = PCW'(i); ld_data_i = prog[i];
      tick();
    end
    ld_we_i = 1'b0;
  endtask

  // Program-level reference: walk the program, emit transfers, read data and the run result.
  task automatic model_run(input bit hold_low);
    int pc; int err; bit to; bit stop; logic [1:0] op; xfer_t x;
    pc = 0; err = 0; to = 1'b0; stop = 1'b0;
    while (!stop) begin
      op = prog[pc][IW-1 -: 2];
      if (op == 2'b11) stop = 1'b1;
      else if (op == 2'b10) begin
        if (hold_low) begin to = 1'b1; stop = 1'b1; end
      end else begin
        x.w = (op == 2'b00); x.a = prog[pc][DW +: AW]; x.d = prog[pc][DW-1:0];
        exp_x.push_back(x);
        ws_q.push_back(ws_arr[pc]);
        rsp_q.push_back(rsp_arr[pc]);
        if (op == 2'b01) begin
          exp_rd.push_back(rsp_arr[pc]);
          if (rsp_arr[pc] != x.d && err < 65535) err++;
        end
      end
      if (!stop) begin
        if (pc == DEPTH - 1) stop = 1'b1;
        else pc++;
      end
    end
`ifndef MATMUL_SEQ_COMPARE_EN
    err = 0;
`endif
    exp_done.push_back({err[15:0], to});
  endtask

  task automatic run(input bit hold_low, input bit poke, output int lat, output int busy_c,
                     output int setup_c, output int acc_c, output int xfer_c);
    bit seen;
    seen = 1'b0; lat = 0; busy_c = 0; setup_c = 0; acc_c = 0; xfer_c = 0;
    model_run(hold_low);
    done_mode = hold_low ? 1 : 0;
    start_i = 1'b1; tick(); start_i = 1'b0;
    while (!seen && lat < 2000) begin
      @(negedge clk);
      lat++;
      if (busy_o) busy_c++;
      if (psel_o && !penable_o) setup_c++;
      if (penable_o) acc_c++;
      if (psel_o && penable_o && pready_i) xfer_c++;
      if (poke && lat == 3) begin
        start_i = 1'b1; ld_we_i = 1'b1; ld_addr_i = PCW'(3); ld_data_i = {2'b11, {(IW-2){1'b0}}};
      end else begin
        start_i = 1'b0; ld_we_i = 1'b0;
      end
      if (done_o) seen = 1'b1;
    end
    start_i = 1'b0; ld_we_i = 1'b0;
    if (!seen) begin
      vec++; miss++;
      $display("FAIL run_done: done_o not seen after %0d cycles, required within budget", lat);
      do_reset();
    end
    tick(); tick();
    done_mode = 0;
  endtask

  // APB slave: per-transfer wait states and read data come from the model's queues.
  initial forever begin
    @(posedge clk); #2;
    if (psel_o && penable_o) begin
      if (!in_xfer) begin
        in_xfer = 1'b1;
        if (ws_q.size() > 0) begin ws_left = ws_q.pop_front(); cur_rsp = rsp_q.pop_front(); end
        else begin ws_left = 0; cur_rsp = 32'hDEAD_BEEF; end
      end
      if (ws_left == 0) begin pready_i = 1'b1; prdata_i = cur_rsp; in_xfer = 1'b0; end
      else begin pready_i = 1'b0; prdata_i = $urandom; ws_left--; end
    end else begin
      pready_i = 1'b0; prdata_i = $urandom;
    end
  end

  // Completion source: random, but never low long enough to time out unless held low.
  initial begin
    int streak;
    streak = 0;
    forever begin
      @(posedge clk); #2;
      if (done_mode == 1) dut_done_i = 1'b0;
      else if (streak >= 5) begin dut_done_i = 1'b1; streak = 0; end
      else begin
        dut_done_i = ($urandom_range(0, 3) == 0);
        streak = dut_done_i ? 0 : streak + 1;
      end
    end
  end

  // Monitor: pops expected transfers / read data / run results as the DUT presents them.
  initial forever begin
    xfer_t x; logic [16:0] e; logic [DW-1:0] r;
    @(negedge clk);
    if (psel_o && !penable_o) begin setup_a = paddr_o; setup_w = pwrite_o; setup_d = pwdata_o; end
    if (psel_o && penable_o && pready_i) begin
      chk("paddr_stable", paddr_o, setup_a);
      chk("pwrite_stable", pwrite_o, setup_w);
      chk("pwdata_stable", pwdata_o, setup_d);
      if (exp_x.size() == 0) begin
        vec++; miss++;
        $display("FAIL xfer_extra: got transfer to 0x%0h, expected none", paddr_o);
      end else begin
        x = exp_x.pop_front();
        chk("pwrite", pwrite_o, x.w);
        chk("paddr", paddr_o, x.a);
        if (x.w) chk("pwdata", pwdata_o, x.d);
      end
    end
    if (rd_valid_o) begin
      if (exp_rd.size() == 0) begin
        vec++; miss++;
        $display("FAIL rd_extra: got rd_valid with 0x%0h, expected none", rd_data_o);
      end else begin
        r = exp_rd.pop_front();
        chk("rd_data", rd_data_o, r);
      end
    end
    if (done_o) begin
      if (exp_done.size() == 0) begin
        vec++; miss++;
        $display("FAIL done_extra: got done_o, expected none");
      end else begin
        e = exp_done.pop_front();
        chk("err_cnt", err_cnt_o, e[16:1]);
        chk("timeout", timeout_o, e[0]);
        chk("busy_at_done", busy_o, 1'b0);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at 5 ms, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, sc, ac, xc;
    bit found;
    fill_end();
    rst_i = 1'b1; tick(); tick();
    chk("rst_psel", psel_o, 1'b0);       chk("rst_penable", penable_o, 1'b0);
    chk("rst_pwrite", pwrite_o, 1'b0);   chk("rst_paddr", paddr_o, 16'h0);
    chk("rst_pwdata", pwdata_o, 32'h0);  chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);       chk("rst_err", err_cnt_o, 16'h0);
    chk("rst_timeout", timeout_o, 1'b0); chk("rst_rd_data", rd_data_o, 32'h0);
    chk("rst_rd_valid", rd_valid_o, 1'b0);
    rst_i = 1'b0; tick();

    // Single WRITE then END.
    fill_end();
    prog[0] = {2'b00, 16'h0004, 32'hA5A5_0001};
    load_prog();
    run(1'b0, 1'b0, lat, bc, sc, ac, xc);
    chk("write_done_latency_4to5", (lat >= 4 && lat <= 5), 1'b1);
    chk("write_setup_cycles", sc, 1);
    chk("write_access_cycles", ac, 1);

    // READ with three wait states and a mismatching response.
    fill_end();
    prog[0] = {2'b01, 16'h0010, 32'h0000_1234};
    rsp_arr[0] = 32'h0000_1235; ws_arr[0] = 3;
    load_prog();
    run(1'b0, 1'b0, lat, bc, sc, ac, xc);
    chk("read_penable_cycles", ac, 4);

    // WAIT with completion held low times out.
    fill_end();
    prog[0] = {2'b10, {(IW-2){1'b0}}};
    load_prog();
    run(1'b1, 1'b0, lat, bc, sc, ac, xc);
    chk("wait_busy_cycles", bc, TMO + 1);
    chk("wait_busy_after", busy_o, 1'b0);

    // Reset during ACCESS, then replay the retained program.
    fill_end();
    prog[0] = {2'b00, 16'h0020, 32'h1111_2222};
    prog[1] = {2'b00, 16'h0024, 32'h3333_4444};
    ws_arr[0] = 5;
    load_prog();
    model_run(1'b0);
    start_i = 1'b1; tick(); start_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (psel_o && penable_o) found = 1'b1;
    end
    chk("rst_reached_access", found, 1'b1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_psel", psel_o, 1'b0);
    chk("midrst_penable", penable_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    rst_i = 1'b0;
    flush();
    ws_arr[0] = 0;
    run(1'b0, 1'b0, lat, bc, sc, ac, xc);
    chk("replay_xfers", xc, 2);

    // DEPTH WRITEs, no END; start and load attempts while busy are ignored.
    for (int i = 0; i < DEPTH; i++) begin
      prog[i] = {2'b00, AW'(16'h0100 + 16'(4 * i)), 32'($urandom)};
      ws_arr[i] = $urandom_range(0, 1); rsp_arr[i] = '0;
    end
    load_prog();
    run(1'b0, 1'b1, lat, bc, sc, ac, xc);
    chk("wrap_xfers", xc, DEPTH);
    run(1'b0, 1'b0, lat, bc, sc, ac, xc);
    chk("wrap_rerun_xfers", xc, DEPTH);

    // Randomized programs.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        int r;
        r = $urandom_range(0, 15);
        prog[i][DW-1:0] = $urandom;
        prog[i][DW +: AW] = AW'($urandom);
        prog[i][IW-1 -: 2] = (r < 6) ? 2'b00 : (r < 11) ? 2'b01 : (r < 14) ? 2'b10 : 2'b11;
        rsp_arr[i] = $urandom_range(0, 1) ? prog[i][DW-1:0] : (prog[i][DW-1:0] ^ ($urandom | 32'h1));
        ws_arr[i] = $urandom_range(0, 3);
      end
      load_prog();
      run(1'b0, 1'b0, lat, bc, sc, ac, xc);
    end

    chk("exp_xfer_left", exp_x.size(), 0);
    chk("exp_rd_left", exp_rd.size(), 0);
    chk("exp_done_left", exp_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
